alu_74181_serial: RTL and testbench
===================================

ALU_74181_SERIAL -- requirements
Module: alu_74181_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; WIDTH SHALL be a multiple of 4 and >= 4, otherwise elaboration SHALL fail.
REQ-002 SHALL derive localparam SLICES = WIDTH/4: number of 4-bit slices, processed one per cycle.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 s  in  4  function select S3..S0.
REQ-010 m  in  1  mode: 1 = logic, 0 = arithmetic.
REQ-011 cin  in  1  carry-in, active-high (adds 1 when set).
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 f  out  WIDTH  result.
REQ-015 cout  out  1  carry-out of MSB slice, active-high.
REQ-016 a_eq_b  out  1  set when f is all ones.

Function
REQ-017 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Accept = in_valid & in_ready at an edge; a, b, s, m, cin SHALL be captured, slice index k and carry register SHALL load 0 and cin; state -> BUSY.
REQ-019 In BUSY each cycle SHALL compute slice k (bits 4k+3..4k) from captured operands and the carry register, write it into f's holding register, update carry, increment k; LSB slice first.
REQ-020 After slice SLICES-1 is computed, state SHALL go to DONE; out_valid SHALL rise exactly SLICES cycles after the accept edge.
REQ-021 Logic mode (m=1), per bit, s = 0..15: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all ones, A|~B, A|B, A; cin ignored; carry chain forced 0; cout SHALL be 0.
REQ-022 Arithmetic mode (m=0): X = A | (B&S0) | (~B&S1), Y = (A&~B&S2) | (A&B&S3) (S bits replicated per bit); f = (X + Y + cin) mod 2^WIDTH; cout = bit WIDTH of that sum.
REQ-023 Arithmetic function map implied by REQ-022 (plus cin): 0 A; 1 A|B; 2 A|~B; 3 minus 1; 4 A+(A&~B); 5 (A|B)+(A&~B); 6 A-B-1; 7 (A&~B)-1; 8 A+(A&B); 9 A+B; 10 (A|~B)+(A&B); 11 (A&B)-1; 12 A+A; 13 (A|B)+A; 14 (A|~B)+A; 15 A-1.
REQ-024 a_eq_b SHALL equal AND-reduce of final f in both modes, valid only while out_valid=1.
REQ-025 In DONE, f, cout, a_eq_b, out_valid SHALL hold stable until out_valid & out_ready at an edge; then state -> IDLE, out_valid -> 0.
REQ-026 Input changes and in_valid during BUSY/DONE SHALL be ignored; no request is queued.
REQ-027 out_ready in IDLE/BUSY SHALL have no effect.
REQ-028 WIDTH=4: BUSY SHALL last exactly 1 cycle.
REQ-029 Minimum request-to-request period SHALL be SLICES+2 cycles (accept, SLICES busy, DONE handshake, IDLE).

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, k=0, carry=0, f=0, cout=0, a_eq_b=0, out_valid=0, in_ready=1, from any state.
REQ-031 Reset mid-BUSY or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-032 Accept SHALL be blocked in a cycle where rst=1.

Verification (WIDTH=16)
REQ-033 Hold rst 2 cycles, release -> f=0x0000, cout=0, out_valid=0, in_ready=1.
REQ-034 m=0 s=9 a=0xFFFF b=0x0001 cin=0 -> f=0x0000 cout=1 a_eq_b=0; out_valid exactly 4 cycles after accept.
REQ-035 m=0 s=6 a=b=0x1234 cin=1 -> f=0x0000 cout=1 a_eq_b=0; same with cin=0 -> f=0xFFFF cout=0 a_eq_b=1.
REQ-036 m=1 s=6 a=0xF0F0 b=0xFF00 cin=1 -> f=0x0FF0 cout=0; m=1 s=3 -> f=0x0000.
REQ-037 Result ready, out_ready=0 for 3 cycles with in_valid=1 and new operands -> f/cout/out_valid unchanged, in_ready=0; out_ready=1 -> IDLE next cycle, new request accepted only then.
REQ-038 rst=1 for 1 cycle after 2 BUSY cycles -> IDLE next cycle, f=0, out_valid stays 0 for following 10 cycles with in_valid=0.

Source files
------------

// File: rtl/alu_74181_serial_if.sv
// Request/result bus for the bit-serial (nibble-serial) 74181-style ALU.
// The master issues operations and accepts results; the slave is the ALU.
interface alu_74181_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             a_eq_b;

  modport master (
    output in_valid, a, b, s, m, cin, out_ready,
    input  in_ready, out_valid, f, cout, a_eq_b
  );

  modport slave (
    input  in_valid, a, b, s, m, cin, out_ready,
    output in_ready, out_valid, f, cout, a_eq_b
  );
endinterface

// File: rtl/alu_74181_serial.sv
// 74181-compatible ALU that evaluates one 4-bit slice per cycle, LSB slice first,
// rippling the carry through a register between slices.
module alu_74181_serial #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  alu_74181_serial_if.slave bus
);
  localparam int SLICES = WIDTH / 4;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("alu_74181_serial: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic last_slice;
  logic in_ready;
  logic out_valid;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] f_reg;
  logic             cout_reg;

  logic [3:0] a_sl;
  logic [3:0] b_sl;
  logic [3:0] x_sl;
  logic [3:0] y_sl;
  logic [4:0] sum_sl;
  logic [3:0] logic_sl;
  logic [3:0] slice_f;
  logic       slice_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last_slice = (k == K_LAST);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arithmetic: F = X + Y + carry, where X/Y are the 74181 per-bit propagate/generate terms.
  always_comb begin
    a_sl   = a_reg[{k, 2'b00} +: 4];
    b_sl   = b_reg[{k, 2'b00} +: 4];
    x_sl   = a_sl | (b_sl & {4{s_reg[0]}}) | (~b_sl & {4{s_reg[1]}});
    y_sl   = (a_sl & ~b_sl & {4{s_reg[2]}}) | (a_sl & b_sl & {4{s_reg[3]}});
    sum_sl = {1'b0, x_sl} + {1'b0, y_sl} + {4'b0000, carry};
    case (s_reg)
      4'd0:    logic_sl = ~a_sl;
      4'd1:    logic_sl = ~(a_sl | b_sl);
      4'd2:    logic_sl = ~a_sl & b_sl;
      4'd3:    logic_sl = 4'h0;
      4'd4:    logic_sl = ~(a_sl & b_sl);
      4'd5:    logic_sl = ~b_sl;
      4'd6:    logic_sl = a_sl ^ b_sl;
      4'd7:    logic_sl = a_sl & ~b_sl;
      4'd8:    logic_sl = ~a_sl | b_sl;
      4'd9:    logic_sl = ~(a_sl ^ b_sl);
      4'd10:   logic_sl = b_sl;
      4'd11:   logic_sl = a_sl & b_sl;
      4'd12:   logic_sl = 4'hF;
      4'd13:   logic_sl = a_sl | ~b_sl;
      4'd14:   logic_sl = a_sl | b_sl;
      default: logic_sl = a_sl;
    endcase
    if (m_reg) begin
      slice_f = logic_sl;
      slice_c = 1'b0;
    end else begin
      slice_f = sum_sl[3:0];
      slice_c = sum_sl[4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      m_reg    <= 1'b0;
      k        <= '0;
      carry    <= 1'b0;
      f_reg    <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg    <= bus.a;
      b_reg    <= bus.b;
      s_reg    <= bus.s;
      m_reg    <= bus.m;
      k        <= '0;
      carry    <= bus.cin & ~bus.m;
      cout_reg <= 1'b0;
    end else if (state == BUSY) begin
      f_reg[{k, 2'b00} +: 4] <= slice_f;
      carry                  <= slice_c;
      if (last_slice) begin
        k        <= '0;
        cout_reg <= slice_c;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.f         = f_reg;
  assign bus.cout      = cout_reg;
  assign bus.a_eq_b    = out_valid & (&f_reg);
endmodule

// File: tb/tb_alu_74181_serial.sv
// Directed, table-driven bench for alu_74181_serial at WIDTH=16 with
// hand-computed results plus handshake-stall and reset-abort sequences.
module tb_alu_74181_serial;
  localparam int WIDTH = 16;
  localparam int NVEC  = 18;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic [15:0] f;
    logic        cout;
    logic        eq;
  } vec_t;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  vec_t vecs[NVEC];

  alu_74181_serial_if #(.WIDTH(WIDTH)) bus ();

  alu_74181_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOp(input vec_t v);
    bus.a   = v.a;
    bus.b   = v.b;
    bus.s   = v.s;
    bus.m   = v.m;
    bus.cin = v.cin;
  endtask

  // Accepts one request, counts cycles to out_valid and returns the latency (-1 on timeout).
  task automatic applyStimulus(input vec_t v, output int lat);
    driveOp(v);
    bus.in_valid = 1'b1;
    stepCycle();
    bus.in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      stepCycle();
      if (bus.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic releaseResult(input string name);
    bus.out_ready = 1'b1;
    stepCycle();
    bus.out_ready = 1'b0;
    checkOutput({name, "_ov_after"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({name, "_rdy_after"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic setVec(input int i, input logic m, input logic [3:0] s, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic [15:0] f,
                        input logic cout, input logic eq);
    vecs[i].a = a; vecs[i].b = b; vecs[i].s = s; vecs[i].m = m; vecs[i].cin = cin;
    vecs[i].f = f; vecs[i].cout = cout; vecs[i].eq = eq;
  endtask

  initial begin
    int   lat;
    vec_t v;
    n_compared   = 0;
    n_mismatched = 0;

    setVec(0,  1'b0, 4'd9,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    setVec(1,  1'b0, 4'd6,  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
    setVec(2,  1'b0, 4'd6,  16'h1234, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    setVec(3,  1'b1, 4'd6,  16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    setVec(4,  1'b1, 4'd3,  16'hF0F0, 16'hFF00, 1'b1, 16'h0000, 1'b0, 1'b0);
    setVec(5,  1'b0, 4'd9,  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    setVec(6,  1'b0, 4'd0,  16'hABCD, 16'h5A5A, 1'b0, 16'hABCD, 1'b0, 1'b0);
    setVec(7,  1'b0, 4'd0,  16'hABCD, 16'h5A5A, 1'b1, 16'hABCE, 1'b0, 1'b0);
    setVec(8,  1'b0, 4'd15, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    setVec(9,  1'b0, 4'd12, 16'h8001, 16'h1234, 1'b0, 16'h0002, 1'b1, 1'b0);
    setVec(10, 1'b0, 4'd3,  16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    setVec(11, 1'b0, 4'd3,  16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
    setVec(12, 1'b1, 4'd11, 16'h0F0F, 16'h00FF, 1'b1, 16'h000F, 1'b0, 1'b0);
    setVec(13, 1'b1, 4'd12, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    setVec(14, 1'b1, 4'd0,  16'h1234, 16'h0000, 1'b0, 16'hEDCB, 1'b0, 1'b0);
    setVec(15, 1'b1, 4'd9,  16'hF0F0, 16'hFF00, 1'b0, 16'hF00F, 1'b0, 1'b0);
    setVec(16, 1'b0, 4'd6,  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    setVec(17, 1'b0, 4'd4,  16'h00F0, 16'h0030, 1'b0, 16'h01B0, 1'b0, 1'b0);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cin = 1'b0;
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    checkOutput("reset_f", {16'd0, bus.f}, 32'h0000);
    checkOutput("reset_cout", {31'd0, bus.cout}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_a_eq_b", {31'd0, bus.a_eq_b}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("v%0d_latency", i), lat, 32'd4);
      checkOutput($sformatf("v%0d_f", i), {16'd0, bus.f}, {16'd0, vecs[i].f});
      checkOutput($sformatf("v%0d_cout", i), {31'd0, bus.cout}, {31'd0, vecs[i].cout});
      checkOutput($sformatf("v%0d_a_eq_b", i), {31'd0, bus.a_eq_b}, {31'd0, vecs[i].eq});
      releaseResult($sformatf("v%0d", i));
    end

    // Result held while the consumer stalls; new requests are ignored until the handshake.
    applyStimulus(vecs[0], lat);
    checkOutput("stall_latency", lat, 32'd4);
    v.a = 16'h1357; v.b = 16'h2468; v.s = 4'd15; v.m = 1'b1; v.cin = 1'b0;
    v.f = 16'h1357; v.cout = 1'b0; v.eq = 1'b0;
    driveOp(v);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("stall%0d_f", c), {16'd0, bus.f}, 32'h0000);
      checkOutput($sformatf("stall%0d_cout", c), {31'd0, bus.cout}, 32'd1);
      checkOutput($sformatf("stall%0d_out_valid", c), {31'd0, bus.out_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    stepCycle();
    bus.out_ready = 1'b0;
    checkOutput("stall_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    stepCycle();
    bus.in_valid = 1'b0;
    checkOutput("stall_new_accept_in_ready", {31'd0, bus.in_ready}, 32'd0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      stepCycle();
      if (bus.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkOutput("stall_new_latency", lat, 32'd4);
    checkOutput("stall_new_f", {16'd0, bus.f}, {16'd0, v.f});
    checkOutput("stall_new_cout", {31'd0, bus.cout}, 32'd0);
    releaseResult("stall_new");

    // out_ready held high through BUSY must not shorten the operation.
    driveOp(vecs[5]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    stepCycle();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      stepCycle();
      checkOutput($sformatf("early_ready%0d_out_valid", c), {31'd0, bus.out_valid}, 32'd0);
    end
    stepCycle();
    checkOutput("early_ready_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("early_ready_f", {16'd0, bus.f}, {16'd0, vecs[5].f});
    stepCycle();
    bus.out_ready = 1'b0;
    checkOutput("early_ready_done_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset two cycles into BUSY discards the operation.
    driveOp(vecs[2]);
    bus.in_valid = 1'b1;
    stepCycle();
    bus.in_valid = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("abort_f", {16'd0, bus.f}, 32'h0000);
    checkOutput("abort_cout", {31'd0, bus.cout}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("abort%0d_out_valid", c), {31'd0, bus.out_valid}, 32'd0);
      stepCycle();
    end

    // Reset while a result waits in DONE also drops it.
    applyStimulus(vecs[13], lat);
    checkOutput("done_abort_latency", lat, 32'd4);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("done_abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("done_abort_f", {16'd0, bus.f}, 32'h0000);
    checkOutput("done_abort_a_eq_b", {31'd0, bus.a_eq_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
